surf_scan_sequencer: RTL and testbench
======================================

SURF_SCAN_SEQUENCER -- requirements
Module: surf_scan_sequencer

Interface
REQ-001 Parameter N_SAMPLES, default 65, radius samples per plane (2..255).
REQ-002 Parameter DRAIN_CYCLES, default 6, idle cycles after feed before the calculator result is captured (1..255).
REQ-003 Parameter N_PLANES, default 16, planes per scan (1..256).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  single-cycle request to begin a scan.
REQ-007 busy  out  1  high whenever the state is not IDLE.
REQ-008 s_radius  in  16  radius sample input.
REQ-009 s_valid / s_ready  in / out  1 each  sample handshake; transfer when both are high.
REQ-010 calc_en  out  1  enable to the plane surface calculator.
REQ-011 calc_radius  out  16  radius to the calculator.
REQ-012 calc_surf  in  32  surface result from the calculator.
REQ-013 m_surf  out  32  captured plane surface.
REQ-014 m_plane  out  8  index of the plane in m_surf.
REQ-015 m_last  out  1  high with m_valid when m_plane == N_PLANES-1.
REQ-016 m_valid / m_ready  out / in  1 each  result handshake.
REQ-017 vol  out  48  running sum of accepted m_surf values for the current scan.
REQ-018 done  out  1  one-cycle pulse at scan completion.

Function
REQ-019 FSM states are IDLE, LOAD, FEED, DRAIN and OUT; all outputs are registered.
REQ-020 IDLE: start=1 clears vol and the plane counter, then the next state is LOAD.
REQ-021 start is ignored in every state other than IDLE.
REQ-022 LOAD: s_ready=1; each transfer writes s_radius to buf[cnt], and cnt increments from 0.
REQ-023 s_ready is 0 in every state other than LOAD; s_valid gaps only stall LOAD.
REQ-024 On the N_SAMPLES-th LOAD transfer, cnt clears and the next state is FEED.
REQ-025 FEED: calc_en=1 for exactly N_SAMPLES consecutive cycles with calc_radius=buf[0..N_SAMPLES-1] in order; calc_en first rises the cycle after the last LOAD transfer.
REQ-026 After FEED, the next state is DRAIN: calc_en=0 and calc_radius holds its last value.
REQ-027 DRAIN lasts DRAIN_CYCLES cycles; calc_surf is captured into m_surf on the final DRAIN edge.
REQ-028 At the end of DRAIN the next state is OUT, with m_valid=1 and m_plane set to the plane counter.
REQ-029 OUT: m_surf, m_plane and m_last hold stable while m_valid=1 and m_ready=0.
REQ-030 On the m_valid&m_ready edge: m_valid clears, vol += m_surf (48-bit, no overflow possible), and the plane counter increments.
REQ-031 If the accepted plane was N_PLANES-1, done pulses for one cycle and the next state is IDLE; otherwise the next state is LOAD.
REQ-032 vol holds its final value in IDLE until the next accepted start.
REQ-033 busy=1 from the cycle after the accepted start through the cycle done is high; busy=0 from the cycle after done.

Reset
REQ-034 rst=1 forces, on the same edge, state=IDLE and clears busy, s_ready, calc_en, calc_radius, m_valid, m_surf, m_plane, m_last, vol, done and all counters.
REQ-035 rst asserted mid-operation (any state) discards partial buffers with no further calc_en or m_valid pulses.
REQ-036 rst has priority over start, s_valid and m_ready asserted in the same cycle.
REQ-037 Buffer contents need no reset.

Verification
REQ-038 Defaults, one plane, samples 1..65 streamed without gaps, calc_surf=32'h0000_1234 -> calc_en high exactly 65 cycles carrying 1..65; m_surf=32'h1234 at m_plane=0; m_valid 6 cycles after calc_en falls.
REQ-039 N_PLANES=2, m_ready held 0 for 10 cycles in OUT -> m_surf/m_plane stable; then accepted planes with surf 100 and 200 give vol=300, m_last on plane 1, one done pulse, busy=0.
REQ-040 s_valid toggled 1/0 every cycle during LOAD -> all 65 samples captured in order; calc_en still contiguous for 65 cycles.
REQ-041 start pulsed during FEED and OUT; s_valid=1 outside LOAD -> no effect; s_ready=0 outside LOAD.
REQ-042 rst asserted at the 30th FEED cycle -> calc_en=0 next cycle; all outputs 0; a fresh start then runs a full correct plane.
REQ-043 N_SAMPLES=2, DRAIN_CYCLES=1, N_PLANES=1, calc_surf=32'hFFFF_FFFF -> vol=48'h0000_FFFF_FFFF; done 1 cycle after the m_ready handshake.

Source files
------------

// File: rtl/surf_scan_sequencer.sv
// surf_scan_sequencer: buffers one plane of radius samples, streams them
// to an external plane surface calculator, waits for its pipeline to
// drain, then publishes the plane surface and accumulates the scan volume.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  one-cycle scan request (honoured only in IDLE)
//   busy                   scan in progress
//   s_radius/s_valid/s_ready   radius sample stream (LOAD only)
//   calc_en/calc_radius    sample feed to the calculator
//   calc_surf              calculator result, sampled at end of DRAIN
//   m_surf/m_plane/m_last/m_valid/m_ready   per-plane result stream
//   vol                    running sum of accepted plane surfaces
//   done                   one-cycle pulse when the last plane is accepted
module surf_scan_sequencer #(
    parameter int N_SAMPLES    = 65,
    parameter int DRAIN_CYCLES = 6,
    parameter int N_PLANES     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic [15:0] s_radius,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        calc_en,
    output logic [15:0] calc_radius,
    input  logic [31:0] calc_surf,
    output logic [31:0] m_surf,
    output logic [7:0]  m_plane,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] vol,
    output logic        done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;

    localparam int AW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [AW-1:0] IDX0 = '0;
    localparam logic [7:0] SAMP_LAST  = 8'(N_SAMPLES - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [8:0] PLANE_LAST = 9'(N_PLANES - 1);

    logic [2:0]    state;
    logic [7:0]    cnt;
    logic [8:0]    plane;
    logic [AW-1:0] rd_idx;
    logic [15:0]   sample_buf [0:N_SAMPLES-1];

    // In FEED, cnt is the index currently on calc_radius; fetch the next.
    assign rd_idx = cnt[AW-1:0] + AW'(1);

    // s_ready is high exactly in LOAD, so s_valid alone marks a transfer.
    always_ff @(posedge clk) begin
        if (state == LOAD && s_valid) begin
            sample_buf[cnt[AW-1:0]] <= s_radius;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            plane       <= '0;
            busy        <= 1'b0;
            s_ready     <= 1'b0;
            calc_en     <= 1'b0;
            calc_radius <= '0;
            m_surf      <= '0;
            m_plane     <= '0;
            m_last      <= 1'b0;
            m_valid     <= 1'b0;
            vol         <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // busy stays up through the done cycle, drops here
                    busy <= 1'b0;
                    if (start) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        s_ready <= 1'b1;
                        cnt     <= '0;
                        plane   <= '0;
                        vol     <= '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (cnt == SAMP_LAST) begin
                            state       <= FEED;
                            cnt         <= '0;
                            s_ready     <= 1'b0;
                            calc_en     <= 1'b1;
                            calc_radius <= sample_buf[IDX0];
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                FEED: begin
                    if (cnt == SAMP_LAST) begin
                        state   <= DRAIN;
                        cnt     <= '0;
                        calc_en <= 1'b0;
                    end else begin
                        cnt         <= cnt + 8'd1;
                        calc_radius <= sample_buf[rd_idx];
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state   <= OUT;
                        cnt     <= '0;
                        m_surf  <= calc_surf;
                        m_plane <= plane[7:0];
                        m_last  <= (plane == PLANE_LAST);
                        m_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        vol     <= vol + {16'd0, m_surf};
                        plane   <= plane + 9'd1;
                        if (m_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_surf_scan_sequencer.sv
// Directed bench for surf_scan_sequencer: a 65/6/2 instance for the main
// flow and a 2/1/1 instance for the minimal-size, full-scale-result case.
module tb_surf_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, busy, s_valid, s_ready, calc_en;
    logic [15:0] s_radius, calc_radius;
    logic [31:0] calc_surf, m_surf;
    logic [7:0]  m_plane;
    logic        m_last, m_valid, m_ready, done;
    logic [47:0] vol;

    logic        b_start, b_busy, b_s_valid, b_s_ready, b_calc_en;
    logic [15:0] b_s_radius, b_calc_radius;
    logic [31:0] b_calc_surf, b_m_surf;
    logic [7:0]  b_m_plane;
    logic        b_m_last, b_m_valid, b_m_ready, b_done;
    logic [47:0] b_vol;

    int compared = 0;
    int mismatched = 0;

    surf_scan_sequencer #(
        .N_SAMPLES(65), .DRAIN_CYCLES(6), .N_PLANES(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .s_radius(s_radius), .s_valid(s_valid), .s_ready(s_ready),
        .calc_en(calc_en), .calc_radius(calc_radius),
        .calc_surf(calc_surf), .m_surf(m_surf), .m_plane(m_plane),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .vol(vol), .done(done)
    );

    surf_scan_sequencer #(
        .N_SAMPLES(2), .DRAIN_CYCLES(1), .N_PLANES(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy),
        .s_radius(b_s_radius), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .calc_en(b_calc_en), .calc_radius(b_calc_radius),
        .calc_surf(b_calc_surf), .m_surf(b_m_surf), .m_plane(b_m_plane),
        .m_last(b_m_last), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .vol(b_vol), .done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One plane on DUT A, entered with the DUT in LOAD. Radii are
    // base+1..base+65. Returns after the m_ready handshake edge, or after
    // the reset edge when abort_at selects a FEED cycle.
    task automatic run_plane(input int pl, input bit gaps, input int base,
                             input logic [31:0] surf, input bit exp_last,
                             input int hold, input int abort_at);
        bit ok;
        calc_surf = surf;
        ok = 1'b1;
        for (int i = 0; i < 65; i++) begin
            if (s_ready !== 1'b1) ok = 1'b0;
            s_valid  = 1'b1;
            s_radius = 16'(base + i + 1);
            step();
            if (gaps && i < 64) begin
                s_valid  = 1'b0;
                s_radius = 16'hDEAD;
                step();
            end
        end
        // keep s_valid high outside LOAD; it must be ignored
        s_valid  = 1'b1;
        s_radius = 16'hBEEF;
        chk("load_ready", 64'(ok), 64'd1);
        chk("feed_s_ready", 64'(s_ready), 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 65; k++) begin
            if (calc_en !== 1'b1) ok = 1'b0;
            if (calc_radius !== 16'(base + k + 1)) ok = 1'b0;
            if (k == abort_at) begin
                chk("feed_before_rst", 64'(ok), 64'd1);
                rst = 1'b1;
                step();
                rst = 1'b0;
                s_valid = 1'b0;
                return;
            end
            start = (k == 20);
            step();
        end
        start = 1'b0;
        chk("feed_seq", 64'(ok), 64'd1);
        chk("feed_end_en", 64'(calc_en), 64'd0);
        chk("feed_end_radius", 64'(calc_radius), 64'(16'(base + 65)));
        ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            if (m_valid !== 1'b0 || calc_en !== 1'b0) ok = 1'b0;
            if (s_ready !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        chk("drain_quiet", 64'(ok), 64'd1);
        step();
        chk("out_valid", 64'(m_valid), 64'd1);
        chk("out_surf", 64'(m_surf), 64'(surf));
        chk("out_plane", 64'(m_plane), 64'(pl));
        chk("out_last", 64'(m_last), 64'(exp_last));
        chk("out_s_ready", 64'(s_ready), 64'd0);
        if (hold > 0) begin
            m_ready = 1'b0;
            ok = 1'b1;
            for (int h = 0; h < hold; h++) begin
                start = (h == 0);
                step();
                if (m_valid !== 1'b1 || m_surf !== surf) ok = 1'b0;
                if (m_plane !== 8'(pl) || m_last !== exp_last) ok = 1'b0;
            end
            start = 1'b0;
            chk("out_hold_stable", 64'(ok), 64'd1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        chk("accept_valid_low", 64'(m_valid), 64'd0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        start = 1'b0; s_valid = 1'b0; s_radius = '0;
        m_ready = 1'b0; calc_surf = '0;
        b_start = 1'b0; b_s_valid = 1'b0; b_s_radius = '0;
        b_m_ready = 1'b0; b_calc_surf = '0;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_calc_en", 64'(calc_en), 64'd0);
        chk("rst_calc_radius", 64'(calc_radius), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_surf", 64'(m_surf), 64'd0);
        chk("rst_m_plane", 64'(m_plane), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_vol", 64'(vol), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_b_busy", 64'(b_busy), 64'd0);

        rst = 1'b0;
        s_valid = 1'b1;
        step();
        chk("idle_s_ready", 64'(s_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        s_valid = 1'b0;

        // scan 1: plane 0 gapless with a held OUT, plane 1 with s_valid gaps
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_s_ready", 64'(s_ready), 64'd1);
        run_plane(0, 1'b0, 0, 32'h0000_1234, 1'b0, 10, -1);
        chk("p0_vol", 64'(vol), 64'h1234);
        chk("p0_done", 64'(done), 64'd0);
        chk("p0_busy", 64'(busy), 64'd1);
        chk("p0_next_load", 64'(s_ready), 64'd1);
        run_plane(1, 1'b1, 100, 32'd200, 1'b1, 0, -1);
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_busy_done", 64'(busy), 64'd1);
        chk("s1_vol", 64'(vol), 64'd4860);
        chk("s1_last_clr", 64'(m_last), 64'd0);
        step();
        chk("s1_done_pulse", 64'(done), 64'd0);
        chk("s1_busy_idle", 64'(busy), 64'd0);
        chk("s1_vol_hold", 64'(vol), 64'd4860);

        // scan 2: reset on the 30th FEED cycle
        start = 1'b1;
        step();
        start = 1'b0;
        run_plane(0, 1'b0, 500, 32'h55, 1'b0, 0, 29);
        chk("abort_calc_en", 64'(calc_en), 64'd0);
        chk("abort_radius", 64'(calc_radius), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_vol", 64'(vol), 64'd0);
        chk("abort_m_valid", 64'(m_valid), 64'd0);
        chk("abort_m_surf", 64'(m_surf), 64'd0);
        ok = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (calc_en !== 1'b0 || m_valid !== 1'b0) ok = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
        end
        chk("abort_quiet", 64'(ok), 64'd1);

        // scan 3: fresh two-plane scan, 100 + 200
        start = 1'b1;
        step();
        start = 1'b0;
        run_plane(0, 1'b0, 200, 32'd100, 1'b0, 0, -1);
        chk("s3_vol0", 64'(vol), 64'd100);
        run_plane(1, 1'b0, 300, 32'd200, 1'b1, 0, -1);
        chk("s3_vol", 64'(vol), 64'd300);
        chk("s3_done", 64'(done), 64'd1);
        step();
        chk("s3_busy", 64'(busy), 64'd0);
        chk("s3_done_pulse", 64'(done), 64'd0);

        // minimal instance: 2 samples, 1 drain cycle, 1 plane
        b_calc_surf = 32'hFFFF_FFFF;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("b_s_ready", 64'(b_s_ready), 64'd1);
        b_s_valid = 1'b1;
        b_s_radius = 16'd7;
        step();
        b_s_radius = 16'd9;
        step();
        b_s_valid = 1'b0;
        chk("b_feed0_en", 64'(b_calc_en), 64'd1);
        chk("b_feed0_r", 64'(b_calc_radius), 64'd7);
        step();
        chk("b_feed1_en", 64'(b_calc_en), 64'd1);
        chk("b_feed1_r", 64'(b_calc_radius), 64'd9);
        step();
        chk("b_drain_en", 64'(b_calc_en), 64'd0);
        chk("b_drain_r", 64'(b_calc_radius), 64'd9);
        chk("b_drain_valid", 64'(b_m_valid), 64'd0);
        step();
        chk("b_out_valid", 64'(b_m_valid), 64'd1);
        chk("b_out_surf", 64'(b_m_surf), 64'hFFFF_FFFF);
        chk("b_out_last", 64'(b_m_last), 64'd1);
        chk("b_out_plane", 64'(b_m_plane), 64'd0);
        b_m_ready = 1'b1;
        step();
        b_m_ready = 1'b0;
        chk("b_done", 64'(b_done), 64'd1);
        chk("b_vol", 64'(b_vol), 64'h0000_FFFF_FFFF);
        chk("b_busy_done", 64'(b_busy), 64'd1);
        step();
        chk("b_done_pulse", 64'(b_done), 64'd0);
        chk("b_busy_idle", 64'(b_busy), 64'd0);
        chk("b_vol_hold", 64'(b_vol), 64'h0000_FFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
